// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with hazard control for the 5-stage RISC-V core.
// Resolves the ID-side operands from the forwarding unit's selects, inserts a
// bubble on forward_stall or flush, and freezes on mem_stall.
//
// Optional feature (compile-time macro ID_EX_STALL_CNT_EN):
//   adds output stall_cnt, a saturating count of bubbles caused by forward_stall.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ID_valid                         decode slot holds a real instruction
//   ID_rs1/ID_rs2/ID_rd              register indices
//   ID_reg_write/mem_read/mem_write  control bits
//   ID_ctrl                          ALU/branch control
//   ID_imm, ID_pc                    immediate, PC
//   ID_rf_rs1, ID_rf_rs2             register-file read data
//   ME_result, WB_data               forwarding sources
//   forward_c, forward_d             ID operand selects (bit1 = ME, bit0 = WB)
//   forward_stall                    EX-to-ID dependency, insert a bubble
//   mem_stall                        memory not ready, freeze everything
//   flush                            branch/jump taken, squash ID
//   id_hold                          freeze PC and IF/ID
//   ID_op1, ID_op2                   resolved operands (combinational)
//   EX_*                             registered execute-stage fields
//   stall_cnt                        forward_stall bubble count (optional)
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic [4:0]        ID_rs1,
  input  logic [4:0]        ID_rs2,
  input  logic [4:0]        ID_rd,
  input  logic              ID_reg_write,
  input  logic              ID_mem_read,
  input  logic              ID_mem_write,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic [XLEN-1:0]   ID_imm,
  input  logic [XLEN-1:0]   ID_pc,
  input  logic [XLEN-1:0]   ID_rf_rs1,
  input  logic [XLEN-1:0]   ID_rf_rs2,
  input  logic [XLEN-1:0]   ME_result,
  input  logic [XLEN-1:0]   WB_data,
  input  logic [1:0]        forward_c,
  input  logic [1:0]        forward_d,
  input  logic              forward_stall,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              id_hold,
  output logic [XLEN-1:0]   ID_op1,
  output logic [XLEN-1:0]   ID_op2,
  output logic              EX_valid,
  output logic              EX_reg_write,
  output logic              EX_mem_read,
  output logic              EX_mem_write,
  output logic [4:0]        EX_rs1,
  output logic [4:0]        EX_rs2,
  output logic [4:0]        EX_rd,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic [XLEN-1:0]   EX_imm,
  output logic [XLEN-1:0]   EX_pc,
  output logic [XLEN-1:0]   EX_op1,
  output logic [XLEN-1:0]   EX_op2
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // RUN: the register holds a real instruction; BUBBLE: it holds a bubble.
  // A mem_stall hold is simply "no transition".
  typedef enum logic {
    ST_BUBBLE = 1'b0,
    ST_RUN    = 1'b1
  } ex_state_t;

  ex_state_t state_q, state_d;

  logic              reg_write_d, mem_read_d, mem_write_d;
  logic [4:0]        rs1_d, rs2_d, rd_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [XLEN-1:0]   imm_d, pc_d, op1_d, op2_d;

  // Operand resolution: bit1 (ME) wins over bit0 (WB); 11 means both match
  // and the younger ME result is the correct one.
  always_comb begin
    ID_op1 = ID_rf_rs1;
    if (forward_c[1])      ID_op1 = ME_result;
    else if (forward_c[0]) ID_op1 = WB_data;
  end

  always_comb begin
    ID_op2 = ID_rf_rs2;
    if (forward_d[1])      ID_op2 = ME_result;
    else if (forward_d[0]) ID_op2 = WB_data;
  end

  // A flush squashes the ID instruction, so freezing IF/ID on it would be wrong.
  assign id_hold = mem_stall | (forward_stall & ~flush);

  // EX_valid mirrors the state: only a normal load leaves the register valid.
  assign EX_valid = (state_q == ST_RUN);

  // Next-state / next-field logic. Defaults hold every field (mem_stall path).
  always_comb begin
    state_d     = state_q;
    reg_write_d = EX_reg_write;
    mem_read_d  = EX_mem_read;
    mem_write_d = EX_mem_write;
    rs1_d       = EX_rs1;
    rs2_d       = EX_rs2;
    rd_d        = EX_rd;
    ctrl_d      = EX_ctrl;
    imm_d       = EX_imm;
    pc_d        = EX_pc;
    op1_d       = EX_op1;
    op2_d       = EX_op2;
    if (!mem_stall) begin
      if (flush || forward_stall || !ID_valid) begin
        state_d     = ST_BUBBLE;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rs1_d       = '0;
        rs2_d       = '0;
        rd_d        = '0;
        ctrl_d      = '0;
        imm_d       = '0;
        pc_d        = '0;
        op1_d       = '0;
        op2_d       = '0;
      end else begin
        state_d     = ST_RUN;
        reg_write_d = ID_reg_write;
        mem_read_d  = ID_mem_read;
        mem_write_d = ID_mem_write;
        rs1_d       = ID_rs1;
        rs2_d       = ID_rs2;
        rd_d        = ID_rd;
        ctrl_d      = ID_ctrl;
        imm_d       = ID_imm;
        pc_d        = ID_pc;
        op1_d       = ID_op1;
        op2_d       = ID_op2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BUBBLE;
      EX_reg_write <= 1'b0;
      EX_mem_read  <= 1'b0;
      EX_mem_write <= 1'b0;
      EX_rs1       <= '0;
      EX_rs2       <= '0;
      EX_rd        <= '0;
      EX_ctrl      <= '0;
      EX_imm       <= '0;
      EX_pc        <= '0;
      EX_op1       <= '0;
      EX_op2       <= '0;
    end else begin
      state_q      <= state_d;
      EX_reg_write <= reg_write_d;
      EX_mem_read  <= mem_read_d;
      EX_mem_write <= mem_write_d;
      EX_rs1       <= rs1_d;
      EX_rs2       <= rs2_d;
      EX_rd        <= rd_d;
      EX_ctrl      <= ctrl_d;
      EX_imm       <= imm_d;
      EX_pc        <= pc_d;
      EX_op1       <= op1_d;
      EX_op2       <= op2_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  // Counts only bubbles attributable to forward_stall: flush outranks it and
  // mem_stall suppresses the update entirely.
  logic stall_bubble;
  assign stall_bubble = ~mem_stall & ~flush & forward_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_bubble && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Keeps CNT_W referenced when the counter is compiled out.
  localparam int unsigned cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned CNT_W  = 3;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
  } ex_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              ID_valid;
  logic [4:0]        ID_rs1, ID_rs2, ID_rd;
  logic              ID_reg_write, ID_mem_read, ID_mem_write;
  logic [CTRL_W-1:0] ID_ctrl;
  logic [XLEN-1:0]   ID_imm, ID_pc, ID_rf_rs1, ID_rf_rs2, ME_result, WB_data;
  logic [1:0]        forward_c, forward_d;
  logic              forward_stall, mem_stall, flush;
  logic              id_hold;
  logic [XLEN-1:0]   ID_op1, ID_op2;
  logic              EX_valid, EX_reg_write, EX_mem_read, EX_mem_write;
  logic [4:0]        EX_rs1, EX_rs2, EX_rd;
  logic [CTRL_W-1:0] EX_ctrl;
  logic [XLEN-1:0]   EX_imm, EX_pc, EX_op1, EX_op2;
`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  cnt_model;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  ex_t         model;
  ex_t         exp_q[$];

  id_ex_stage #(
    .XLEN   (XLEN),
    .CTRL_W (CTRL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ID_valid      (ID_valid),
    .ID_rs1        (ID_rs1),
    .ID_rs2        (ID_rs2),
    .ID_rd         (ID_rd),
    .ID_reg_write  (ID_reg_write),
    .ID_mem_read   (ID_mem_read),
    .ID_mem_write  (ID_mem_write),
    .ID_ctrl       (ID_ctrl),
    .ID_imm        (ID_imm),
    .ID_pc         (ID_pc),
    .ID_rf_rs1     (ID_rf_rs1),
    .ID_rf_rs2     (ID_rf_rs2),
    .ME_result     (ME_result),
    .WB_data       (WB_data),
    .forward_c     (forward_c),
    .forward_d     (forward_d),
    .forward_stall (forward_stall),
    .mem_stall     (mem_stall),
    .flush         (flush),
    .id_hold       (id_hold),
    .ID_op1        (ID_op1),
    .ID_op2        (ID_op2),
    .EX_valid      (EX_valid),
    .EX_reg_write  (EX_reg_write),
    .EX_mem_read   (EX_mem_read),
    .EX_mem_write  (EX_mem_write),
    .EX_rs1        (EX_rs1),
    .EX_rs2        (EX_rs2),
    .EX_rd         (EX_rd),
    .EX_ctrl       (EX_ctrl),
    .EX_imm        (EX_imm),
    .EX_pc         (EX_pc),
    .EX_op1        (EX_op1),
    .EX_op2        (EX_op2)
`ifdef ID_EX_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd_model(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] me, input logic [XLEN-1:0] wb);
    case (sel)
      2'b00:   return rf;
      2'b01:   return wb;
      default: return me;
    endcase
  endfunction

  task automatic rand_id();
    ID_rs1       = 5'($urandom);
    ID_rs2       = 5'($urandom);
    ID_rd        = 5'($urandom);
    ID_reg_write = 1'($urandom);
    ID_mem_read  = 1'($urandom);
    ID_mem_write = 1'($urandom);
    ID_ctrl      = CTRL_W'($urandom);
    ID_imm       = $urandom;
    ID_pc        = $urandom;
    ID_rf_rs1    = $urandom;
    ID_rf_rs2    = $urandom;
    ME_result    = $urandom;
    WB_data      = $urandom;
  endtask

  task automatic set_ctl(input logic ms, input logic fl, input logic fs);
    mem_stall     = ms;
    flush         = fl;
    forward_stall = fs;
  endtask

  task automatic check_ex(input ex_t e);
    check_val("ex_valid",     EX_valid,     e.valid);
    check_val("ex_reg_write", EX_reg_write, e.reg_write);
    check_val("ex_mem_read",  EX_mem_read,  e.mem_read);
    check_val("ex_mem_write", EX_mem_write, e.mem_write);
    check_val("ex_rs1",       EX_rs1,       e.rs1);
    check_val("ex_rs2",       EX_rs2,       e.rs2);
    check_val("ex_rd",        EX_rd,        e.rd);
    check_val("ex_ctrl",      EX_ctrl,      e.ctrl);
    check_val("ex_imm",       EX_imm,       e.imm);
    check_val("ex_pc",        EX_pc,        e.pc);
    check_val("ex_op1",       EX_op1,       e.op1);
    check_val("ex_op2",       EX_op2,       e.op2);
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic step();
    logic [XLEN-1:0] e1, e2;
    ex_t             e;
    #1;
    e1 = fwd_model(forward_c, ID_rf_rs1, ME_result, WB_data);
    e2 = fwd_model(forward_d, ID_rf_rs2, ME_result, WB_data);
    check_val("id_op1", ID_op1, e1);
    check_val("id_op2", ID_op2, e2);
    check_val("id_hold", id_hold, mem_stall || (forward_stall && !flush));
    if (!mem_stall) begin
      if (flush || forward_stall || !ID_valid) begin
        model = '0;
      end else begin
        model = '{valid: 1'b1, reg_write: ID_reg_write, mem_read: ID_mem_read,
                  mem_write: ID_mem_write, rs1: ID_rs1, rs2: ID_rs2, rd: ID_rd,
                  ctrl: ID_ctrl, imm: ID_imm, pc: ID_pc, op1: e1, op2: e2};
      end
`ifdef ID_EX_STALL_CNT_EN
      if (!flush && forward_stall && cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + 1'b1;
`endif
    end
    exp_q.push_back(model);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_ex(e);
    end
`ifdef ID_EX_STALL_CNT_EN
    check_val("stall_cnt", stall_cnt, cnt_model);
`endif
    @(negedge clk);
  endtask

  logic [XLEN-1:0] fwd_tbl [4];

  initial begin
    fwd_tbl[0] = 32'h11;
    fwd_tbl[1] = 32'h33;
    fwd_tbl[2] = 32'h22;
    fwd_tbl[3] = 32'h22;
    rst = 1'b1;
    ID_valid = 1'b0;
    forward_c = 2'b00;
    forward_d = 2'b00;
    set_ctl(1'b0, 1'b0, 1'b0);
    rand_id();
    model = '0;
`ifdef ID_EX_STALL_CNT_EN
    cnt_model = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_ex('0);
`ifdef ID_EX_STALL_CNT_EN
    check_val("rst_stall_cnt", stall_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Load-use bubble, then the held instruction loads on the next edge.
    rand_id();
    ID_valid = 1'b1;
    ID_rd = 5'd7;
    ID_reg_write = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b1);
    #1;
    check_val("lu_hold", id_hold, 1);
    step();
    check_val("lu_bubble_valid", EX_valid, 0);
    set_ctl(1'b0, 1'b0, 1'b0);
    step();
    check_val("lu_load_rd", EX_rd, 7);

    // Forward priority on both operands.
    for (int s = 0; s < 4; s++) begin
      rand_id();
      ID_valid  = 1'b1;
      ID_rf_rs1 = 32'h11;
      ID_rf_rs2 = 32'h11;
      ME_result = 32'h22;
      WB_data   = 32'h33;
      forward_c = s[1:0];
      forward_d = 2'(3 - s);
      #1;
      check_val("fwd_tbl_op1", ID_op1, fwd_tbl[s]);
      check_val("fwd_tbl_op2", ID_op2, fwd_tbl[3 - s]);
      step();
      check_val("fwd_tbl_ex_op1", EX_op1, fwd_tbl[s]);
    end
    forward_c = 2'b00;
    forward_d = 2'b00;

    // Memory stall holds EX_pc for 3 cycles.
    rand_id();
    ID_valid = 1'b1;
    ID_pc = 32'h100;
    step();
    ID_pc = 32'h104;
    set_ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("ms_pc_hold", EX_pc, 32'h100);
    end
    set_ctl(1'b0, 1'b0, 1'b0);
    step();
    check_val("ms_pc_release", EX_pc, 32'h104);

    // Flush together with forward_stall.
    rand_id();
    ID_valid = 1'b1;
    set_ctl(1'b0, 1'b1, 1'b1);
    #1;
    check_val("fl_fs_hold", id_hold, 0);
    step();
    check_val("fl_fs_valid", EX_valid, 0);

    // mem_stall dominates flush; dropping it with flush still high bubbles.
    rand_id();
    ID_valid = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0);
    step();
    set_ctl(1'b1, 1'b1, 1'b0);
    step();
    check_val("ms_fl_valid_held", EX_valid, 1);
    set_ctl(1'b0, 1'b1, 1'b0);
    step();
    check_val("ms_fl_bubble", EX_valid, 0);

    // Asynchronous reset between edges, held through a stall.
    rand_id();
    ID_valid = 1'b1;
    ID_rd = 5'd5;
    ID_reg_write = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0);
    step();
    check_val("pre_rst_rd", EX_rd, 5);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_rd", EX_rd, 0);
    check_val("async_rst_rw", EX_reg_write, 0);
    check_val("async_rst_valid", EX_valid, 0);
    model = '0;
`ifdef ID_EX_STALL_CNT_EN
    check_val("async_rst_cnt", stall_cnt, 0);
    cnt_model = '0;
`endif
    set_ctl(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_val("rst_stall_rd", EX_rd, 0);
    @(negedge clk);
    rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0);
    rand_id();
    ID_valid = 1'b1;
    step();
    check_val("post_rst_valid", EX_valid, 1);

    // Random traffic, including enough forward_stalls to saturate the counter.
    for (int i = 0; i < 300; i++) begin
      rand_id();
      ID_valid  = ($urandom_range(0, 7) != 0);
      forward_c = 2'($urandom);
      forward_d = 2'($urandom);
      set_ctl($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with hazard control for the 5-stage RISC-V core. Sits between decode and execute.
- Resolves the ID-side operands using the forwarding unit's ID selects (forward_c / forward_d).
- Inserts a bubble when the forwarding unit raises forward_stall.
- Holds on memory stall; squashes on branch flush.
- Its EX_* outputs feed back into the forwarding unit.

Parameters:
- XLEN, 32, datapath width
- CTRL_W, 6, packed ALU/branch control width
- CNT_W, 16, stall counter width (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ID_valid  in  1  decode slot holds a real instruction
- ID_rs1, ID_rs2, ID_rd  in  5 each  register indices
- ID_reg_write, ID_mem_read, ID_mem_write  in  1 each  control bits
- ID_ctrl  in  CTRL_W  ALU/branch control
- ID_imm, ID_pc  in  XLEN each  immediate, PC
- ID_rf_rs1, ID_rf_rs2  in  XLEN each  register-file read data
- ME_result, WB_data  in  XLEN each  forwarding sources
- forward_c, forward_d  in  2 each  ID operand selects
- forward_stall  in  1  EX-to-ID dependency
- mem_stall  in  1  cache/memory not ready
- flush  in  1  branch/jump taken, squash ID
- id_hold  out  1  freeze PC and IF/ID
- ID_op1, ID_op2  out  XLEN each  resolved operands (comb., for ID branch compare)
- EX_valid, EX_reg_write, EX_mem_read, EX_mem_write  out  1 each
- EX_rs1, EX_rs2, EX_rd  out  5 each
- EX_ctrl  out  CTRL_W
- EX_imm, EX_pc, EX_op1, EX_op2  out  XLEN each

Behaviour:
- **Reset.** Asynchronous on rst high. Every EX_* output goes to 0; the stall counter goes to 0.
- **Operand mux (combinational).** Select bit1 has priority: 1x -> ME_result; 01 -> WB_data; 00 -> ID_rf. Value 11 means both stages match, and ME_result wins. ID_op1 uses forward_c; ID_op2 uses forward_d.
- **id_hold.** id_hold = mem_stall | (forward_stall & ~flush). Combinational, no latency.
- **Per-cycle register update.** Priority is mem_stall > flush > forward_stall > load:
  1. mem_stall=1: all EX_* hold their values, including a bubble. This holds even if flush or forward_stall is also high; those are re-evaluated once mem_stall drops.
  2. flush=1: load a bubble.
  3. forward_stall=1: load a bubble. The ID instruction is held upstream by id_hold.
  4. Otherwise: load all ID_* fields; EX_op1/EX_op2 take ID_op1/ID_op2.
- **Bubble definition.** All EX_* fields are 0, so EX_valid=0, EX_reg_write=0 and EX_rd=0.
- **Load with ID_valid=0.** Loads a bubble.
- **Stall self-clearing.** The bubble clears EX_reg_write, so forward_stall deasserts the next cycle. A single forward_stall therefore costs exactly 1 cycle.
- **Latency.** 1 cycle from ID_* to EX_*.
- **State view.** The block is a 2-state machine per cycle:
  - RUN: a normal load.
  - BUBBLE: a bubble was inserted.
  - HOLD is not a state; it is the absence of update.
- **Simultaneous flush and forward_stall.** Flush wins and id_hold=0, so IF/ID is not frozen on a squashed instruction.
- **Reset mid-stall.** Outputs clear immediately. After release the first un-stalled edge loads normally.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- **Defined:** adds output stall_cnt [CNT_W-1:0].
  - Increments by 1 on each edge where a bubble is loaded because of forward_stall (not flush, not ID_valid=0).
  - Saturates at all-ones.
  - Cleared by rst.
  - Does not count during mem_stall.
- **Undefined:** the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- **Reset mid-operation.** Load ID_rd=5, ID_reg_write=1, then assert rst asynchronously between edges -> EX_rd=0, EX_reg_write=0 immediately, before the next edge.
- **Forward priority.** ID_rf_rs1=0x11, ME_result=0x22, WB_data=0x33, then forward_c=00/01/10/11 -> ID_op1=0x11/0x33/0x22/0x22. After a load edge, EX_op1 equals that value.
- **Load-use bubble.** forward_stall=1 for one cycle with ID_rd=7 -> id_hold=1 and next EX_valid=0, EX_rd=0; the following edge loads EX_rd=7. With ID_EX_STALL_CNT_EN, stall_cnt=1.
- **Memory stall.** Hold mem_stall=1 for 3 cycles with EX_pc=0x100 and ID_pc=0x104 -> EX_pc stays 0x100 and id_hold=1 for all 3 cycles. After release, EX_pc=0x104.
- **Flush vs stall.** flush=1 and forward_stall=1 together -> id_hold=0, next EX_valid=0, stall_cnt unchanged.
- **Stall during mem_stall.** mem_stall=1 with flush=1 -> EX_* unchanged. Drop mem_stall while flush=1 -> a bubble is loaded on that edge.
